// File: rtl/lfsr_prng.sv
// Parametrised Fibonacci LFSR pseudo-random generator with multi-step advance,
// run-time seed load, stall enable, lock-up recovery and period-wrap marker.
module lfsr_prng #(
    parameter int unsigned      WIDTH = 16,
    parameter logic [WIDTH-1:0] TAPS  = 16'hB400,
    parameter bit               XNOR  = 1'b0,
    parameter int unsigned      STEPS = 1,
    parameter logic [WIDTH-1:0] SEED  = 16'h0001
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_en,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_seed,
    output logic [WIDTH-1:0] o_out,
    output logic             o_wrap,
    output logic             o_lockup
);

    // The one state the feedback can never leave on its own.
    localparam logic [WIDTH-1:0] LOCK = {WIDTH{XNOR}};

    generate
        if (WIDTH < 3 || WIDTH > 64) begin : g_bad_width
            $error("lfsr_prng: WIDTH must be in 3..64");
        end else if (STEPS < 1 || STEPS > WIDTH) begin : g_bad_steps
            $error("lfsr_prng: STEPS must be in 1..WIDTH");
        end else if (TAPS[WIDTH-1] != 1'b1) begin : g_bad_taps
            $error("lfsr_prng: TAPS[WIDTH-1] must be set");
        end else if (SEED == LOCK) begin : g_bad_seed
            $error("lfsr_prng: SEED must differ from the lock state");
        end
    endgenerate

    function automatic logic [WIDTH-1:0] lfsr_step(input logic [WIDTH-1:0] s);
        logic fb;
        fb = (^(s & TAPS)) ^ XNOR;
        return {s[WIDTH-2:0], fb};
    endfunction

    logic [WIDTH-1:0] state_q, state_d;
    logic             wrap_q, wrap_d;
    logic             lock_q, lock_d;
    logic [WIDTH-1:0] adv;

    always_comb begin
        adv = state_q;
        for (int unsigned k = 0; k < STEPS; k++) begin
            adv = lfsr_step(adv);
        end
    end

    // Load beats recovery, recovery beats advance; pulses only come from the latter two.
    always_comb begin
        state_d = state_q;
        wrap_d  = 1'b0;
        lock_d  = 1'b0;
        if (i_load) begin
            state_d = i_seed;
        end else if (state_q == LOCK) begin
            state_d = SEED;
            lock_d  = 1'b1;
        end else if (i_en) begin
            state_d = adv;
            wrap_d  = (adv == SEED);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= SEED;
            wrap_q  <= 1'b0;
            lock_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            wrap_q  <= wrap_d;
            lock_q  <= lock_d;
        end
    end

    assign o_out    = state_q;
    assign o_wrap   = wrap_q;
    assign o_lockup = lock_q;

endmodule

// File: doc/lfsr_prng.md
# lfsr_prng

Parametrised Fibonacci LFSR pseudo-random generator for the random-display and test-pattern paths. It adds several things a fixed 16-bit generator lacks:
- configurable width, tap polynomial and XOR/XNOR feedback;
- multiple shifts per clock;
- run-time seed load;
- a stall enable;
- automatic lock-up recovery with a status pulse;
- a period-wrap marker.

It sits between the clock domain's control logic and any consumer of pseudo-random words (hex display drivers, scramblers, stimulus generators).

## Interface
Parameters:
- WIDTH, 16, state width in bits; legal 3..64
- TAPS, 16'hB400, feedback tap mask; bit i set means state[i] feeds back; TAPS[WIDTH-1] must be 1
- XNOR, 0, 0 = XOR feedback (lock state all-zeros), 1 = XNOR feedback (lock state all-ones)
- STEPS, 1, LFSR shifts applied per enabled clock; legal 1..WIDTH
- SEED, 16'h0001, reset and recovery state; must differ from the lock state

Ports:
- clk  input  1  clock
- rst_n  input  1  asynchronous, active-low reset
- i_en  input  1  advance state by STEPS shifts this cycle
- i_load  input  1  load i_seed into state this cycle
- i_seed  input  WIDTH  value loaded when i_load=1
- o_out  output  WIDTH  current LFSR state
- o_wrap  output  1  one-cycle pulse: state returned to SEED by advancing
- o_lockup  output  1  one-cycle pulse: lock state was replaced by SEED

## Operation
- Single shift step f(s):
  - fb = XOR of s[i] over all i with TAPS[i]=1, inverted when XNOR=1.
  - f(s) = {s[WIDTH-2:0], fb}, i.e. shift left with fb entering bit 0.
- Advance: next = f applied STEPS times, computed combinationally in one cycle.
- Lock state L = all-zeros (XNOR=0) or all-ones (XNOR=1).
- Per-cycle priority, highest first:
  1. i_load=1: state <= i_seed. Any value is accepted, including L. o_wrap=0, o_lockup=0.
  2. Else state==L: state <= SEED and o_lockup=1, regardless of i_en. o_wrap=0.
  3. Else i_en=1: state <= next, and o_wrap <= (next==SEED).
  4. Else: hold; o_wrap=0, o_lockup=0.
- o_wrap and o_lockup are registered and high for exactly one cycle per event. They go low on the following cycle unless the event repeats.
- A load that happens to equal SEED does not raise o_wrap.
- Parameter violations fail elaboration via a generate-time check. Violations are:
  - WIDTH out of range;
  - STEPS out of range;
  - TAPS[WIDTH-1]=0;
  - SEED == L.

## Timing
- Reset (async assert, sync release): o_out=SEED, o_wrap=0, o_lockup=0.
- Latency:
  - i_en, i_load and recovery all take effect on o_out at the next rising edge.
  - No combinational path from inputs to outputs.
- Lock recovery: L is visible on o_out for exactly one cycle after loading it, then SEED with o_lockup=1.
- Reset asserted mid-operation: outputs return to reset values immediately. The first advance after release starts from SEED.
- Period: with a maximal-length TAPS, the state sequence has period 2^WIDTH-1 shifts. With STEPS=k, o_wrap recurs every (2^WIDTH-1)/gcd(k, 2^WIDTH-1) enabled cycles.

## Test plan
- Test 1, STEPS=1 sequence:
  - Config: WIDTH=4, TAPS=4'hC, XNOR=0, STEPS=1, SEED=1; release reset, i_en=1.
  - o_out must run 1,2,4,9,3,6,D,A,5,B,7,F,E,C,8,1.
  - o_wrap=1 only on the 15th enabled cycle, coincident with o_out=1.
- Test 2, STEPS=2 with stall:
  - Same config with STEPS=2.
  - o_out must run 1,4,3,D,5,7,E,8,2,9,6,A,B,F,C,1.
  - o_wrap on the 15th enabled cycle.
  - With i_en=0 for 3 cycles mid-run, o_out holds and o_wrap stays 0.
- Test 3, load then recovery:
  - From o_out=6, pulse i_load with i_seed=0.
  - Next cycle o_out=0 and o_lockup=0.
  - Following cycle o_out=1 and o_lockup=1 (with i_en=0).
  - Then o_lockup=0.
- Test 4, XNOR lock state:
  - Config: XNOR=1, WIDTH=4, SEED=0; load i_seed=F.
  - Recovery to 0 with a single o_lockup pulse.
  - Advancing from 0 gives 1 (fb = ~(0^0) = 1).
- Test 5, load priority:
  - Hold i_load=1 and i_en=1 together with i_seed=A.
  - o_out=A the next cycle; no advance, no pulses.
- Test 6, async reset and default width:
  - Assert rst_n=0 asynchronously mid-run, between clock edges.
  - o_out=SEED and both pulses 0 immediately.
  - For WIDTH=16 defaults, the first enabled advance from 0001 gives 0002.
